// File: rtl/muldiv_iter.sv
// muldiv_iter: multi-cycle HI/LO multiply/divide unit for the MIPS datapath.
// Executes mult, multu, div, divu, mthi and mtlo and owns the HI/LO registers.
// The iterative engine is radix-2 shift-add (multiply) and radix-2 restoring
// division. Operands are converted to magnitudes at accept, and signs are
// applied in FIX.
// Optional feature macro: MULDIV_RADIX4_EN selects a radix-4 multiply
// (2 bits per ITER cycle). Divide is always radix-2.

`ifndef MULT
`define MULT  3'b000
`endif
`ifndef MULTU
`define MULTU 3'b001
`endif
`ifndef DIV
`define DIV   3'b010
`endif
`ifndef DIVU
`define DIVU  3'b011
`endif
`ifndef MTH
`define MTH   3'b100
`endif
`ifndef MTL
`define MTL   3'b101
`endif

module muldiv_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  mult_op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

`ifdef MULDIV_RADIX4_EN
   localparam logic [5:0] MUL_CNT = 6'd16;
`else
   localparam logic [5:0] MUL_CNT = 6'd32;
`endif
   localparam logic [5:0] DIV_CNT = 6'd32;

   // Two's-complement magnitude; 0x80000000 maps onto itself, which is the
   // correct unsigned magnitude.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
      logic [31:0] r;
      if (neg) begin
         r = ~v + 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t      state_r, state_nxt_s;
   logic [5:0]  cnt_r;
   logic [63:0] acc_r;       // mult: {partial product, multiplier}; div: {remainder, quotient}
   logic [31:0] opb_r;       // mult: multiplicand magnitude; div: divisor magnitude
   logic        is_div_r;
   logic        neg_q_r;     // negate product / quotient
   logic        neg_r_r;     // negate remainder

   logic        is_mul_s, is_div_s, is_signed_s, is_mth_s, is_mtl_s;
   logic        accept_s, accept_iter_s, div_zero_s;
   logic        sign_a_s, sign_b_s;
   logic [31:0] mag_a_s, mag_b_s;

   logic [63:0] step_s;
   logic [31:0] rem_sub_s;
   logic        rem_ge_s;
`ifdef MULDIV_RADIX4_EN
   logic [33:0] mul_add_s, mul_sum_s;
`else
   logic [32:0] mul_add_s, mul_sum_s;
`endif

   logic [63:0] prod_s;
   logic [31:0] fix_hi_s, fix_lo_s;

   logic        busy_nxt_s, done_nxt_s;
   logic [31:0] hi_nxt_s, lo_nxt_s;

   // Decode the requested operation and form operand magnitudes and signs.
   always_comb begin
      is_mul_s    = 1'b0;
      is_div_s    = 1'b0;
      is_signed_s = 1'b0;
      is_mth_s    = 1'b0;
      is_mtl_s    = 1'b0;
      case (mult_op)
         `MULT:  begin is_mul_s = 1'b1; is_signed_s = 1'b1; end
         `MULTU: begin is_mul_s = 1'b1; end
         `DIV:   begin is_div_s = 1'b1; is_signed_s = 1'b1; end
         `DIVU:  begin is_div_s = 1'b1; end
         `MTH:   begin is_mth_s = 1'b1; end
         `MTL:   begin is_mtl_s = 1'b1; end
         default: begin is_mul_s = 1'b0; end
      endcase
      sign_a_s      = is_signed_s & rs[31];
      sign_b_s      = is_signed_s & rt[31];
      mag_a_s       = mag32(rs, sign_a_s);
      mag_b_s       = mag32(rt, sign_b_s);
      accept_s      = start & ~cancel & (state_r == ST_IDLE);
      div_zero_s    = is_div_s & (rt == 32'd0);
      accept_iter_s = accept_s & (is_mul_s | (is_div_s & ~div_zero_s));
   end

   // One iteration step of the multiply or divide engine.
   always_comb begin
      mul_add_s = '0;
      mul_sum_s = '0;
      rem_sub_s = acc_r[62:31] - opb_r;
      rem_ge_s  = acc_r[63] | (acc_r[62:31] >= opb_r);
      if (is_div_r) begin
         if (rem_ge_s) begin
            step_s = {rem_sub_s, acc_r[30:0], 1'b1};
         end else begin
            step_s = {acc_r[62:0], 1'b0};
         end
      end else begin
`ifdef MULDIV_RADIX4_EN
         case (acc_r[1:0])
            2'b00:   mul_add_s = 34'd0;
            2'b01:   mul_add_s = {2'b00, opb_r};
            2'b10:   mul_add_s = {1'b0, opb_r, 1'b0};
            2'b11:   mul_add_s = {2'b00, opb_r} + {1'b0, opb_r, 1'b0};
            default: mul_add_s = 34'd0;
         endcase
         mul_sum_s = {2'b00, acc_r[63:32]} + mul_add_s;
         step_s    = {mul_sum_s, acc_r[31:2]};
`else
         if (acc_r[0]) begin
            mul_add_s = {1'b0, opb_r};
         end else begin
            mul_add_s = 33'd0;
         end
         mul_sum_s = {1'b0, acc_r[63:32]} + mul_add_s;
         step_s    = {mul_sum_s, acc_r[31:1]};
`endif
      end
   end

   // Sign fixup of the finished result.
   always_comb begin
      if (neg_q_r) begin
         prod_s = ~acc_r + 64'd1;
      end else begin
         prod_s = acc_r;
      end
      if (is_div_r) begin
         fix_lo_s = mag32(acc_r[31:0], neg_q_r);
         fix_hi_s = mag32(acc_r[63:32], neg_r_r);
      end else begin
         fix_lo_s = prod_s[31:0];
         fix_hi_s = prod_s[63:32];
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; cancel always returns to IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_iter_s) begin
               state_nxt_s = ST_ITER;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ITER: begin
            if (cancel) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == 6'd1) begin
               state_nxt_s = ST_FIX;
            end else begin
               state_nxt_s = ST_ITER;
            end
         end
         ST_FIX:  state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM output logic: next values of busy, done, hi and lo.
   always_comb begin
      busy_nxt_s = (state_nxt_s == ST_ITER) | (state_nxt_s == ST_FIX);
      done_nxt_s = 1'b0;
      hi_nxt_s   = hi;
      lo_nxt_s   = lo;
      if (accept_s) begin
         done_nxt_s = is_mth_s | is_mtl_s | div_zero_s;
         if (is_mth_s) begin
            hi_nxt_s = rs;
         end else if (is_mtl_s) begin
            lo_nxt_s = rs;
         end else begin
            hi_nxt_s = hi;
         end
      end else if ((state_r == ST_FIX) && !cancel) begin
         done_nxt_s = 1'b1;
         hi_nxt_s   = fix_hi_s;
         lo_nxt_s   = fix_lo_s;
      end else begin
         done_nxt_s = 1'b0;
      end
   end

   // Registered architectural outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         hi   <= 32'd0;
         lo   <= 32'd0;
      end else begin
         busy <= busy_nxt_s;
         done <= done_nxt_s;
         hi   <= hi_nxt_s;
         lo   <= lo_nxt_s;
      end
   end

   // Engine datapath: operand latch at accept, one step per ITER cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r    <= 6'd0;
         acc_r    <= 64'd0;
         opb_r    <= 32'd0;
         is_div_r <= 1'b0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
      end else if (accept_iter_s) begin
         is_div_r <= is_div_s;
         neg_q_r  <= sign_a_s ^ sign_b_s;
         neg_r_r  <= sign_a_s & is_div_s;
         if (is_div_s) begin
            cnt_r <= DIV_CNT;
            acc_r <= {32'd0, mag_a_s};
            opb_r <= mag_b_s;
         end else begin
            cnt_r <= MUL_CNT;
            acc_r <= {32'd0, mag_b_s};
            opb_r <= mag_a_s;
         end
      end else if ((state_r == ST_ITER) && !cancel) begin
         cnt_r <= cnt_r - 6'd1;
         acc_r <= step_s;
      end else if (cancel) begin
         cnt_r <= 6'd0;
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule
